mmio_io_port: RTL and testbench
===============================

MMIO_IO_PORT -- requirements
Module: mmio_io_port

Interface
REQ-001 clk  input  1  Sole clock; all state updates on its rising edge.
REQ-002 reset  input  1  Synchronous, active-high reset.
REQ-003 addr  input  16  CPU memory-stage byte address.
REQ-004 wdata  input  16  CPU store data.
REQ-005 mem_write  input  1  CPU store strobe, one cycle per store.
REQ-006 mem_read  input  1  CPU load strobe, one cycle per load.
REQ-007 hit  output  1  Combinational; high when addr falls in IO_BASE..IO_BASE+3.
REQ-008 rdata  output  16  Combinational load data, valid in the same cycle as mem_read.
REQ-009 in  input  16  Host input word.
REQ-010 in_valid  input  1  Host presents `in`.
REQ-011 in_ready  output  1  Port accepts `in`; a transfer occurs when in_valid and in_ready are both high at a clock edge.
REQ-012 out  output  16  Last word stored to DATA_OUT; held stable between stores.
REQ-013 out_valid  output  1  An unacknowledged store to DATA_OUT is pending.
REQ-014 out_ack  input  1  Host acknowledgement of `out`.

Function
REQ-015 Address map: IO_BASE=0xFF00; +0 DATA_IN (R); +1 DATA_OUT (R/W); +2 STATUS (R); +3 CONTROL (W).
REQ-016 The port decodes only when hit=1; mem_read/mem_write outside the map have no effect, and rdata=0x0000.
REQ-017 Input buffer: in_ready = not full; an accepted word is written at the tail.
REQ-018 A DATA_IN read when non-empty returns the head word in the same cycle; the head is popped at that clock edge.
REQ-019 A DATA_IN read when empty returns 0x0000, pops nothing, and sets STATUS.underflow.
REQ-020 On simultaneous push and pop, both take effect; occupancy is unchanged; ordering is preserved.
REQ-021 in_valid=1 while full -> the word is dropped and STATUS.overflow is set.
REQ-022 DATA_OUT write: out<=wdata at the edge; out_valid<=1.
REQ-023 A write while out_valid=1 overwrites `out`; out_valid stays 1.
REQ-024 out_ack while out_valid=1 clears out_valid at the edge; out_ack with out_valid=0 is ignored.
REQ-025 Simultaneous DATA_OUT write and out_ack: the write wins; out_valid=1 with the new value.
REQ-026 A DATA_OUT read returns the current `out`.
REQ-027 STATUS bits: bit0 in_avail (non-empty); bit1 out_valid; bit2 overflow (sticky); bit3 underflow (sticky); bits 15:4 read 0.
REQ-028 CONTROL write: bit0=1 clears overflow; bit1=1 clears underflow; bit2=1 flushes the input buffer; all other bits are ignored.
REQ-029 If a flag clear and the event that sets the same flag occur in the same cycle, the set wins.
REQ-030 A flush coincident with a push leaves the buffer empty; the pushed word is discarded.

Reset
REQ-031 When reset=1 at an edge: buffer empty; out=0x0000; out_valid=0; overflow=0; underflow=0.
REQ-032 While reset=1: in_ready=0; mem_write, mem_read and out_ack are ignored.
REQ-033 A reset asserted mid-transfer discards all pending data with no partial state.

Configuration
REQ-034 Macro IO_IN_FIFO_EN defined: the input buffer is a 2-entry FIFO.
REQ-035 Macro IO_IN_FIFO_EN undefined: the input buffer is a single holding register (full = 1 word); all other behaviour is identical.

Structure
REQ-036 Package io_port_pkg holds IO_BASE, the register offsets, the STATUS/CONTROL bit indices and the data width (16).
REQ-037 Sub-module io_in_fifo (push, pop, flush, full, empty, head) implements the buffer; its depth is selected by IO_IN_FIFO_EN.
REQ-038 Decode, status and output registers reside in mmio_io_port.

Verification
REQ-039 Reset; push in=4 -> STATUS=0x0001; read 0xFF00 -> rdata=4 that cycle; next cycle STATUS=0x0000.
REQ-040 Store 3 to 0xFF01 -> next cycle out=3, out_valid=1; out_ack -> out_valid=0, out still 3.
REQ-041 (FIFO enabled) Push 5, 12, 60 with no reads -> in_ready=0 after 2 words, STATUS=0x0005, reads return 5 then 12; write CONTROL=0x0001 -> overflow cleared.
REQ-042 Read 0xFF00 when empty -> rdata=0x0000, STATUS bit3=1; same-cycle CONTROL=0x0002 write and empty read -> bit3 stays 1.
REQ-043 Same-cycle store 7 to 0xFF01 and out_ack with out_valid=1 -> out=7, out_valid=1.
REQ-044 Assert reset with one word buffered and out_valid=1 -> all outputs at their REQ-031 values on the following cycle.

Source files
------------

// File: rtl/io_port_pkg.sv
// ============================================================================
// io_port_pkg -- shared constants and types for the memory-mapped IO port
// Rev 1.0 -- initial release
// ============================================================================
`default_nettype none

package io_port_pkg;

  localparam int          DATA_W  = 16;
  localparam logic [15:0] IO_BASE = 16'hFF00;

  // Register offsets within the four-word window
  typedef enum logic [1:0] {
    REG_DATA_IN  = 2'd0,
    REG_DATA_OUT = 2'd1,
    REG_STATUS   = 2'd2,
    REG_CONTROL  = 2'd3
  } io_reg_e;

  localparam int STAT_IN_AVAIL  = 0;
  localparam int STAT_OUT_VALID = 1;
  localparam int STAT_OVERFLOW  = 2;
  localparam int STAT_UNDERFLOW = 3;

  localparam int CTRL_CLR_OVF = 0;
  localparam int CTRL_CLR_UDF = 1;
  localparam int CTRL_FLUSH   = 2;

  typedef struct packed {
    logic [11:0] rsvd;
    logic        underflow;
    logic        overflow;
    logic        out_valid;
    logic        in_avail;
  } status_t;

  function automatic logic addr_hit(input logic [15:0] a);
    return a[15:2] == IO_BASE[15:2];
  endfunction

endpackage

`default_nettype wire

// File: rtl/io_in_fifo.sv
// ============================================================================
// io_in_fifo -- host input buffer; 2 entries with IO_IN_FIFO_EN, else 1 word
// Rev 1.0 -- initial release
// ============================================================================
`default_nettype none

module io_in_fifo
  import io_port_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

`ifdef IO_IN_FIFO_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  wr_idx;

  // Entry 0 is always the head; a pop shifts the rest down
  assign wr_idx = count - CNT_W'(pop);
  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);
  assign head   = mem[0];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (pop) begin
        for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (push && wr_idx == CNT_W'(i)) mem[i] <= din;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mmio_io_port.sv
// ============================================================================
// mmio_io_port -- CPU-visible IO port at 0xFF00..0xFF03 with host handshakes.
// Build option: IO_IN_FIFO_EN selects a 2-entry input FIFO (else 1 word).
// Rev 1.0 -- initial release
// ============================================================================
`default_nettype none

module mmio_io_port
  import io_port_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              mem_write,
  input  logic              mem_read,
  output logic              hit,
  output logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  input  logic              out_ack
);

  io_reg_e           reg_sel;
  logic              rd_data_in;
  logic              wr_out;
  logic              wr_ctrl;
  logic              push;
  logic              pop;
  logic              flush;
  logic              ovf_set;
  logic              udf_set;
  logic              full;
  logic              empty;
  logic [DATA_W-1:0] head;
  logic              overflow;
  logic              underflow;
  status_t           status;

  assign hit     = addr_hit(addr);
  assign reg_sel = io_reg_e'(addr[1:0]);

  // Every CPU and host action is masked while reset is held
  assign rd_data_in = !reset && mem_read  && hit && (reg_sel == REG_DATA_IN);
  assign wr_out     = !reset && mem_write && hit && (reg_sel == REG_DATA_OUT);
  assign wr_ctrl    = !reset && mem_write && hit && (reg_sel == REG_CONTROL);

  assign in_ready = !reset && !full;
  assign push     = in_valid && in_ready;
  assign ovf_set  = !reset && in_valid && full;
  assign pop      = rd_data_in && !empty;
  assign udf_set  = rd_data_in && empty;
  assign flush    = wr_ctrl && wdata[CTRL_FLUSH];

  io_in_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (in),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      out       <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      // A flag set in the same cycle as its clear takes precedence
      overflow  <= ovf_set || (overflow  && !(wr_ctrl && wdata[CTRL_CLR_OVF]));
      underflow <= udf_set || (underflow && !(wr_ctrl && wdata[CTRL_CLR_UDF]));
      if (wr_out) begin
        out       <= wdata;
        out_valid <= 1'b1;
      end else if (out_ack) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    status           = '0;
    status.in_avail  = !empty;
    status.out_valid = out_valid;
    status.overflow  = overflow;
    status.underflow = underflow;
  end

  always_comb begin
    rdata = '0;
    if (hit) begin
      case (reg_sel)
        REG_DATA_IN:  rdata = empty ? '0 : head;
        REG_DATA_OUT: rdata = out;
        REG_STATUS:   rdata = status;
        default:      rdata = '0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mmio_io_port.sv
// ============================================================================
// tb_mmio_io_port -- vector table, corner sequences and random traffic
// Rev 1.0 -- initial release
// ============================================================================
`default_nettype none

module tb_mmio_io_port;

`ifdef IO_IN_FIFO_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr, wdata, din, dout, rdata;
  logic        mem_write, mem_read, hit, in_valid, in_ready, out_valid, out_ack;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [15:0] q[$];
  logic [15:0] m_out;
  logic        m_ov, m_ovf, m_udf;

  mmio_io_port dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
    .mem_write(mem_write), .mem_read(mem_read), .hit(hit), .rdata(rdata),
    .in(din), .in_valid(in_valid), .in_ready(in_ready),
    .out(dout), .out_valid(out_valid), .out_ack(out_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_hit(input logic [15:0] a);
    return (a >= 16'hFF00) && (a <= 16'hFF03);
  endfunction

  function automatic logic [15:0] m_rdata(input logic [15:0] a);
    if (!m_hit(a)) return 16'h0000;
    case (a - 16'hFF00)
      16'd0:   return (q.size() > 0) ? q[0] : 16'h0000;
      16'd1:   return m_out;
      16'd2:   return {12'h000, m_udf, m_ovf, m_ov, q.size() > 0};
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_edge(input logic r, input logic [15:0] a, input logic [15:0] wd,
                            input logic wr, input logic rd, input logic [15:0] d,
                            input logic dv, input logic ack);
    logic h, rd_in, wr_o, wr_c, do_pop, do_push, ovf_s, udf_s;
    if (r) begin
      q.delete(); m_out = 0; m_ov = 0; m_ovf = 0; m_udf = 0;
      return;
    end
    h       = m_hit(a);
    rd_in   = rd && h && (a == 16'hFF00);
    wr_o    = wr && h && (a == 16'hFF01);
    wr_c    = wr && h && (a == 16'hFF03);
    do_pop  = rd_in && q.size() > 0;
    udf_s   = rd_in && q.size() == 0;
    do_push = dv && q.size() < DEPTH;
    ovf_s   = dv && q.size() >= DEPTH;
    if (wr_c && wd[2]) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(d);
    end
    m_ovf = ovf_s || (m_ovf && !(wr_c && wd[0]));
    m_udf = udf_s || (m_udf && !(wr_c && wd[1]));
    if (wr_o) begin m_out = wd; m_ov = 1; end
    else if (ack) m_ov = 0;
  endtask

  // One clock: drive, sample combinational outputs, clock, sample state outputs
  task automatic cycle(input logic r, input logic [15:0] a, input logic [15:0] wd,
                       input logic wr, input logic rd, input logic [15:0] d,
                       input logic dv, input logic ack,
                       output logic s_hit, output logic [15:0] s_rdata, output logic s_ir,
                       output logic [15:0] s_out, output logic s_ov);
    reset = r; addr = a; wdata = wd; mem_write = wr; mem_read = rd;
    din = d; in_valid = dv; out_ack = ack;
    #2;
    s_hit = hit; s_rdata = rdata; s_ir = in_ready;
    check("model_hit", {15'd0, hit}, {15'd0, m_hit(a)});
    check("model_rdata", rdata, m_rdata(a));
    check("model_in_ready", {15'd0, in_ready}, {15'd0, !r && q.size() < DEPTH});
    @(posedge clk);
    model_edge(r, a, wd, wr, rd, d, dv, ack);
    #1;
    s_out = dout; s_ov = out_valid;
    check("model_out", dout, m_out);
    check("model_out_valid", {15'd0, out_valid}, {15'd0, m_ov});
  endtask

  typedef struct {
    logic r; logic [15:0] a, wd; logic wr, rd; logic [15:0] d; logic dv, ack;
    logic e_hit; logic [15:0] e_rdata; logic e_ir; logic [15:0] e_out; logic e_ov;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic        h, ir, ov, full1;
    logic [15:0] rv, o;
    logic [15:0] vals[3];
    vals[0] = 16'd5; vals[1] = 16'd12; vals[2] = 16'd60;
    full1 = (DEPTH > 1);
    q.delete(); m_out = 0; m_ov = 0; m_ovf = 0; m_udf = 0;

    //                r  addr     wdata    wr rd din      dv ack | hit rdata   ir     out      ov
    tbl.push_back('{1, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0,   0, 16'h0000, 0,     16'h0000, 0});
    tbl.push_back('{0, 16'hFF02, 16'h0000, 0, 1, 16'h0000, 0, 0,   1, 16'h0000, 1,     16'h0000, 0});
    tbl.push_back('{0, 16'h0000, 16'h0000, 0, 0, 16'h0004, 1, 0,   0, 16'h0000, 1,     16'h0000, 0});
    tbl.push_back('{0, 16'hFF02, 16'h0000, 0, 1, 16'h0000, 0, 0,   1, 16'h0001, full1, 16'h0000, 0});
    tbl.push_back('{0, 16'hFF00, 16'h0000, 0, 1, 16'h0000, 0, 0,   1, 16'h0004, full1, 16'h0000, 0});
    tbl.push_back('{0, 16'hFF02, 16'h0000, 0, 1, 16'h0000, 0, 0,   1, 16'h0000, 1,     16'h0000, 0});
    tbl.push_back('{0, 16'hFF01, 16'h0003, 1, 0, 16'h0000, 0, 0,   1, 16'h0000, 1,     16'h0003, 1});
    tbl.push_back('{0, 16'hFF02, 16'h0000, 0, 1, 16'h0000, 0, 0,   1, 16'h0002, 1,     16'h0003, 1});
    tbl.push_back('{0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 1,   0, 16'h0000, 1,     16'h0003, 0});
    tbl.push_back('{0, 16'hFF01, 16'h0000, 0, 1, 16'h0000, 0, 0,   1, 16'h0003, 1,     16'h0003, 0});
    tbl.push_back('{0, 16'hFF00, 16'h0000, 0, 1, 16'h0000, 0, 0,   1, 16'h0000, 1,     16'h0003, 0});
    tbl.push_back('{0, 16'hFF02, 16'h0000, 0, 1, 16'h0000, 0, 0,   1, 16'h0008, 1,     16'h0003, 0});
    tbl.push_back('{0, 16'hFF03, 16'h0002, 1, 0, 16'h0000, 0, 0,   1, 16'h0000, 1,     16'h0003, 0});
    tbl.push_back('{0, 16'hFF02, 16'h0000, 0, 1, 16'h0000, 0, 0,   1, 16'h0000, 1,     16'h0003, 0});
    tbl.push_back('{0, 16'hFF01, 16'h0007, 1, 0, 16'h0000, 0, 0,   1, 16'h0003, 1,     16'h0007, 1});
    tbl.push_back('{0, 16'hFF01, 16'h0009, 1, 0, 16'h0000, 0, 1,   1, 16'h0007, 1,     16'h0009, 1});
    tbl.push_back('{0, 16'hFF02, 16'h0000, 0, 1, 16'h0000, 0, 0,   1, 16'h0002, 1,     16'h0009, 1});
    tbl.push_back('{0, 16'h0001, 16'h0005, 1, 0, 16'h0000, 0, 0,   0, 16'h0000, 1,     16'h0009, 1});
    tbl.push_back('{0, 16'hFEFF, 16'h0000, 0, 1, 16'h0000, 0, 0,   0, 16'h0000, 1,     16'h0009, 1});
    tbl.push_back('{0, 16'hFF04, 16'h0005, 1, 0, 16'h0000, 0, 0,   0, 16'h0000, 1,     16'h0009, 1});

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].r, tbl[i].a, tbl[i].wd, tbl[i].wr, tbl[i].rd, tbl[i].d, tbl[i].dv, tbl[i].ack,
            h, rv, ir, o, ov);
      check($sformatf("vec%0d_hit", i), {15'd0, h}, {15'd0, tbl[i].e_hit});
      check($sformatf("vec%0d_rdata", i), rv, tbl[i].e_rdata);
      check($sformatf("vec%0d_in_ready", i), {15'd0, ir}, {15'd0, tbl[i].e_ir});
      check($sformatf("vec%0d_out", i), o, tbl[i].e_out);
      check($sformatf("vec%0d_out_valid", i), {15'd0, ov}, {15'd0, tbl[i].e_ov});
    end

    // Fill past capacity: last word dropped, overflow set, order preserved
    cycle(0, 16'h0000, 0, 0, 0, 0, 0, 1, h, rv, ir, o, ov);
    for (int k = 0; k <= DEPTH; k++) begin
      cycle(0, 16'h0000, 0, 0, 0, vals[k], 1, 0, h, rv, ir, o, ov);
      if (k == DEPTH) check("fill_in_ready_low", {15'd0, ir}, 16'd0);
    end
    cycle(0, 16'hFF02, 0, 0, 1, 0, 0, 0, h, rv, ir, o, ov);
    check("fill_status", rv, 16'h0005);
    for (int k = 0; k < DEPTH; k++) begin
      cycle(0, 16'hFF00, 0, 0, 1, 0, 0, 0, h, rv, ir, o, ov);
      check($sformatf("fill_read%0d", k), rv, vals[k]);
    end
    cycle(0, 16'hFF03, 16'h0001, 1, 0, 0, 0, 0, h, rv, ir, o, ov);
    cycle(0, 16'hFF02, 0, 0, 1, 0, 0, 0, h, rv, ir, o, ov);
    check("ovf_cleared", rv, 16'h0000);

    // Overflow clear coincident with a new overflow: the set wins
    for (int k = 0; k < DEPTH; k++) cycle(0, 16'h0000, 0, 0, 0, vals[k], 1, 0, h, rv, ir, o, ov);
    cycle(0, 16'hFF03, 16'h0001, 1, 0, 16'h00EE, 1, 0, h, rv, ir, o, ov);
    cycle(0, 16'hFF02, 0, 0, 1, 0, 0, 0, h, rv, ir, o, ov);
    check("ovf_set_wins", rv, 16'h0005);
    cycle(0, 16'hFF03, 16'h0005, 1, 0, 0, 0, 0, h, rv, ir, o, ov);
    cycle(0, 16'hFF02, 0, 0, 1, 0, 0, 0, h, rv, ir, o, ov);
    check("flush_and_clear", rv, 16'h0000);

    // Flush coincident with a push discards the pushed word
    cycle(0, 16'hFF03, 16'h0004, 1, 0, 16'h1234, 1, 0, h, rv, ir, o, ov);
    cycle(0, 16'hFF02, 0, 0, 1, 0, 0, 0, h, rv, ir, o, ov);
    check("flush_push_status", rv, 16'h0000);

    // Reset with data buffered and out pending
    cycle(0, 16'h0000, 0, 0, 0, 16'h00AA, 1, 0, h, rv, ir, o, ov);
    cycle(0, 16'hFF01, 16'h5555, 1, 0, 0, 0, 0, h, rv, ir, o, ov);
    check("pre_reset_out", o, 16'h5555);
    cycle(1, 16'hFF01, 16'h7777, 1, 0, 16'h00BB, 1, 1, h, rv, ir, o, ov);
    check("reset_in_ready", {15'd0, ir}, 16'd0);
    check("reset_out", o, 16'h0000);
    check("reset_out_valid", {15'd0, ov}, 16'd0);
    cycle(0, 16'hFF02, 0, 0, 1, 0, 0, 0, h, rv, ir, o, ov);
    check("post_reset_status", rv, 16'h0000);
    cycle(0, 16'hFF00, 0, 0, 1, 0, 0, 0, h, rv, ir, o, ov);
    check("post_reset_data_in", rv, 16'h0000);

    // Randomized traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      logic        r, wr, rd, dv, ack;
      logic [15:0] a, wd, d;
      r   = ($urandom_range(0, 63) == 0);
      a   = ($urandom_range(0, 3) != 0) ? (16'hFF00 + 16'($urandom_range(0, 3))) : 16'($urandom);
      wr  = ($urandom_range(0, 2) == 0);
      rd  = ($urandom_range(0, 2) == 0);
      dv  = ($urandom_range(0, 1) == 0);
      ack = ($urandom_range(0, 3) == 0);
      wd  = 16'($urandom);
      d   = 16'($urandom);
      cycle(r, a, wd, wr, rd, d, dv, ack, h, rv, ir, o, ov);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
